// File: rtl/fsk_frame_tx.sv
// fsk_frame_tx: byte-framed FSK transmitter driving a frequency word into the
// DDS/FM modulator. Each byte goes out as preamble (only when starting from
// IDLE), start bit, 8 data bits LSB first, and a stop bit. A one-byte holding
// buffer lets consecutive bytes go out back to back without a repeated preamble.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | no frame; Fre_word follows live mark_fre, waiting for a byte
// S_PREAMBLE | PREAMBLE_BITS alternating bits, mark first
// S_START    | one space bit
// S_DATA     | 8 data bits, LSB first, mark=1 / space=0
// S_STOP     | one mark bit; frame_done on its last cycle, then chain or idle
module fsk_frame_tx #(
    parameter int PHASE_WIDTH   = 32,
    parameter int PREAMBLE_BITS = 8
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic [7:0]             data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [15:0]            baud_div,
    input  logic [PHASE_WIDTH-1:0] mark_fre,
    input  logic [PHASE_WIDTH-1:0] space_fre,
    output logic [PHASE_WIDTH-1:0] Fre_word,
    output logic                   tx_active,
    output logic                   frame_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_START    = 3'd2,
        S_DATA     = 3'd3,
        S_STOP     = 3'd4
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BITS - 1);

    state_t                 state, state_nxt;
    logic                   buf_full, buf_full_nxt;
    logic [7:0]             buf_data, buf_data_nxt;
    logic [7:0]             shift_reg, shift_nxt;
    logic [7:0]             bit_cnt, bit_cnt_nxt;
    logic [15:0]            baud_cnt, baud_cnt_nxt;
    logic [15:0]            baud_lat, baud_lat_nxt;
    logic [PHASE_WIDTH-1:0] mark_lat, mark_lat_nxt;
    logic [PHASE_WIDTH-1:0] space_lat, space_lat_nxt;
    logic [PHASE_WIDTH-1:0] fre_nxt;
    logic                   tx_active_nxt;
    logic                   frame_done_nxt;
    logic                   accept;
    logic                   load;
    logic                   bit_end;

    assign data_ready = !buf_full && !RST;
    assign accept     = data_valid && data_ready;
    assign bit_end    = (baud_cnt == baud_lat - 16'd1);

    // State register and registered outputs, all updated on the same edge.
    always_ff @(posedge clk_in) begin
        if (RST) begin
            state      <= S_IDLE;
            buf_full   <= 1'b0;
            buf_data   <= 8'd0;
            shift_reg  <= 8'd0;
            bit_cnt    <= 8'd0;
            baud_cnt   <= 16'd0;
            baud_lat   <= 16'd0;
            mark_lat   <= '0;
            space_lat  <= '0;
            Fre_word   <= '0;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            buf_full   <= buf_full_nxt;
            buf_data   <= buf_data_nxt;
            shift_reg  <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            baud_cnt   <= baud_cnt_nxt;
            baud_lat   <= baud_lat_nxt;
            mark_lat   <= mark_lat_nxt;
            space_lat  <= space_lat_nxt;
            Fre_word   <= fre_nxt;
            tx_active  <= tx_active_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Next-state, bit sequencing, buffer handshake and output word selection.
    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_reg;
        bit_cnt_nxt   = bit_cnt;
        baud_cnt_nxt  = baud_cnt;
        baud_lat_nxt  = baud_lat;
        mark_lat_nxt  = mark_lat;
        space_lat_nxt = space_lat;
        fre_nxt       = Fre_word;
        load          = 1'b0;

        if (state != S_IDLE) begin
            baud_cnt_nxt = bit_end ? 16'd0 : baud_cnt + 16'd1;
        end

        case (state)
            S_IDLE: begin
                fre_nxt = mark_fre;
                if (buf_full) begin
                    load      = 1'b1;
                    state_nxt = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (bit_end) begin
                    if (bit_cnt == PRE_LAST) begin
                        state_nxt   = S_START;
                        bit_cnt_nxt = 8'd0;
                        fre_nxt     = space_lat;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 8'd1;
                        // next preamble bit index is odd when the current one is even
                        fre_nxt     = bit_cnt[0] ? mark_lat : space_lat;
                    end
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = 8'd0;
                    fre_nxt     = shift_reg[0] ? mark_lat : space_lat;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 8'd7) begin
                        state_nxt = S_STOP;
                        fre_nxt   = mark_lat;
                    end else begin
                        shift_nxt   = {1'b0, shift_reg[7:1]};
                        bit_cnt_nxt = bit_cnt + 8'd1;
                        fre_nxt     = shift_reg[1] ? mark_lat : space_lat;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (buf_full) begin
                        load      = 1'b1;
                        state_nxt = S_START;
                        fre_nxt   = space_fre;
                    end else begin
                        state_nxt = S_IDLE;
                        fre_nxt   = mark_fre;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                fre_nxt   = mark_fre;
            end
        endcase

        // Frame start: take the buffered byte and freeze the timing/frequency setup.
        if (load) begin
            shift_nxt     = buf_data;
            bit_cnt_nxt   = 8'd0;
            baud_cnt_nxt  = 16'd0;
            baud_lat_nxt  = (baud_div == 16'd0) ? 16'd1 : baud_div;
            mark_lat_nxt  = mark_fre;
            space_lat_nxt = space_fre;
        end

        // Unload only happens with buf_full set and accept only with it clear.
        buf_full_nxt = load ? 1'b0 : (accept ? 1'b1 : buf_full);
        buf_data_nxt = accept ? data_in : buf_data;

        tx_active_nxt  = (state_nxt != S_IDLE);
        frame_done_nxt = (state_nxt == S_STOP) && (baud_cnt_nxt == baud_lat_nxt - 16'd1);
    end

endmodule
